pc_word_packet_arbiter: RTL

//  Packet-atomic round-robin arbiter sharing the single PC upstream word channel among N coded streams.

---
 rtl/pc_word_packet_arbiter_if.sv | 31 +++
 rtl/pc_word_packet_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_word_packet_arbiter_if.sv
// Word channel bundle between N coded streams and the shared PC output.
// Ports: in_d/in_v/in_a per input, out_d/out_v/out_a toward the PC side.
interface pc_word_packet_arbiter_if #(
    parameter int N_IN = 4,
    parameter int W    = 32
);
    logic [N_IN*W-1:0] in_d;
    logic [N_IN-1:0]   in_v;
    logic [N_IN-1:0]   in_a;
    logic [W-1:0]      out_d;
    logic              out_v;
    logic              out_a;

    modport slave (
        input  in_d,
        input  in_v,
        input  out_a,
        output in_a,
        output out_d,
        output out_v
    );

    modport master (
        output in_d,
        output in_v,
        output out_a,
        input  in_a,
        input  out_d,
        input  out_v
    );
endinterface

// File: rtl/pc_word_packet_arbiter.sv
// Packet-atomic round-robin arbiter for the PC upstream word channel.
// Ports: clk, reset (async, active-low), bus (slave modport of the word
// channel), pkt_len/en_mask config, grant_idx/busy/timeout_err status.
// Optional: define PC_ARB_TIMEOUT_EN to abort packets whose granted input
// stalls for 2**TMO_W-1 cycles.
module pc_word_packet_arbiter #(
    parameter  int N_IN  = 4,
    parameter  int W     = 32,
    parameter  int LW    = 3,
    parameter  int TMO_W = 8,
    localparam int GW    = $clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_word_packet_arbiter_if.slave bus,
    input  logic [N_IN*LW-1:0]   pkt_len,
    input  logic [N_IN-1:0]      en_mask,
    output logic [GW-1:0]        grant_idx,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [LW-1:0] word_cnt_q, word_cnt_d;
    logic [LW-1:0] len_q, len_d;

    logic [N_IN-1:0] req;
    logic            found;
    logic [GW-1:0]   pick;
    logic [LW-1:0]   pick_len;
    logic            xfer;
    logic            last_word;
    logic            abort;

    // Search starts just past the last winner, so every enabled
    // requester is served once per rotation.
    always_comb begin : arb
        int idx;
        idx   = 0;
        req   = bus.in_v & en_mask;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_IN; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_IN;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        pick_len = pkt_len[pick*LW +: LW];
        if (pick_len == '0) begin
            pick_len = LW'(1);
        end
    end

    always_comb begin : pass
        bus.out_d = '0;
        bus.out_v = 1'b0;
        bus.in_a  = '0;
        if (state_q == S_LOCKED) begin
            bus.out_d         = bus.in_d[grant_q*W +: W];
            bus.out_v         = bus.in_v[grant_q];
            bus.in_a[grant_q] = bus.out_a;
        end
    end

    assign xfer      = bus.out_v && bus.out_a;
    assign last_word = (word_cnt_q == len_q - LW'(1));

`ifdef PC_ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             stall;

    // Counts cycles the locked source has nothing to offer; only a real
    // transfer restarts it, so a source toggling in_v cannot hold forever.
    always_comb begin : tmo
        stall = (state_q == S_LOCKED) && !bus.in_v[grant_q];
        tmo_d = tmo_q;
        if (state_q != S_LOCKED || xfer) begin
            tmo_d = '0;
        end else if (stall) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        abort = stall && (tmo_q == TMO_MAX - TMO_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = abort;
`else
    // Without the stall timeout the grant only ends on the last word.
    assign abort       = (TMO_W < 0);
    assign timeout_err = 1'b0;
`endif

    always_comb begin : fsm
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (found) begin
                    state_d    = S_LOCKED;
                    grant_d    = pick;
                    len_d      = pick_len;
                    word_cnt_d = '0;
                end
            end
            (state_q == S_LOCKED): begin
                if (abort || (xfer && last_word)) begin
                    state_d    = S_IDLE;
                    rr_ptr_d   = grant_q;
                    grant_d    = '0;
                    word_cnt_d = '0;
                end else if (xfer) begin
                    word_cnt_d = word_cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= GW'(N_IN - 1);
            grant_q    <= '0;
            word_cnt_q <= '0;
            len_q      <= LW'(1);
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q == S_LOCKED);

endmodule
